mux_pipe_stage: RTL and testbench
=================================

# mux_pipe_stage

Parametrised N-way, WIDTH-bit select multiplexer with a registered output stage and valid/ready handshake, the pipelined successor to the datapath's fixed-width combinational muxes. Used between MIPS pipeline stages (e.g. writeback/forwarding source selection) where the selected operand must be registered and the downstream stage can stall. Out-of-range selects produce zero, as in the existing 5-input mux, and are flagged and counted.

## Interface
- WIDTH, 32, data lane width in bits
- N, 5, number of input lanes (2..16)
- SEL_W, 3, select width; 2^SEL_W >= N required
- CNT_W, 8, width of the out-of-range event counter
- clk  input  1  clock; everything is on the rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  upstream offers in_data/in_sel
- in_ready  output  1  stage can accept this cycle
- in_data  input  N*WIDTH  lane i = in_data[i*WIDTH +: WIDTH]
- in_sel  input  SEL_W  lane select
- out_valid  output  1  out_data/out_err valid
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  selected lane, registered
- out_err  output  1  entry was produced by in_sel >= N
- err_cnt  output  CNT_W  saturating count of accepted out-of-range selects

## Operation
- Accept: in_valid && in_ready on a rising edge. Output transfer: out_valid && out_ready.
- On accept: captured data = lane[in_sel] if in_sel < N, else 0 with err bit 1; err_cnt increments by 1 when err bit 1, saturating at 2^CNT_W-1 (no wrap).
- Main register (out_data, out_err, out_valid) holds until transferred; contents never change while out_valid && !out_ready (except via skid path below, which never overwrites main).
- Simultaneous output transfer and accept: main register loads new entry; out_valid stays 1.
- Output transfer without accept: out_valid -> 0 next cycle.
- in_data/in_sel ignored when in_valid is 0 or in_ready is 0.
- Order preserved; no entry dropped or duplicated.

## Timing
- Reset values: out_valid 0, out_data 0, out_err 0, err_cnt 0, skid empty; in_ready 1 in the cycle after rst deasserts (in_ready 0 while rst is 1).
- rst mid-operation discards all held entries regardless of handshake state; err_cnt cleared.
- Latency: accept at edge k -> out_valid=1 with the data visible after edge k, i.e. one cycle.
- Without skid (see Configuration): in_ready = !out_valid || out_ready (combinational from out_ready); full throughput, one entry of storage.
- With skid: two-entry storage; in_ready is a register output = skid empty. If accept occurs while main full and !out_ready, entry goes to skid, in_ready -> 0 next cycle. On next output transfer, skid moves to main, in_ready -> 1. Full throughput sustained with out_ready held 1.

## Configuration
- MUX_PIPE_STAGE_SKID_EN defined: skid buffer compiled in; in_ready registered, no combinational path out_ready -> in_ready; capacity 2.
- Not defined: no skid storage; in_ready combinational as above; capacity 1. Data/err/err_cnt behaviour identical in both builds.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 -> out_valid 0, out_data 0, err_cnt 0 throughout; first accept only after rst low.
- Lane select, N=5, lane i = 32'h1000_0000+i, out_ready=1, in_sel 0..4 back-to-back -> out_data 1000_0000..1000_0004 on consecutive cycles, out_err 0, one per cycle.
- Out of range: in_sel 5, 6, 7 -> out_data 0, out_err 1 each, err_cnt = 3; CNT_W=2 with 5 such selects -> err_cnt stays 3.
- Backpressure: out_ready=0 for 4 cycles while in_valid=1 -> out_data held stable; no skid build: 1 entry accepted; skid build: 2 accepted then in_ready 0; release -> entries emerge in order, none lost.
- Simultaneous: out_valid=1, out_ready=1, in_valid=1 in same cycle -> out_valid stays 1, out_data updates to new entry next cycle.
- Reset mid-stall with skid full -> next cycle out_valid 0, in_ready 1 after rst low, stale entries never appear.

Source files
------------

// File: rtl/mux_pipe_stage.sv
`default_nettype none
// ============================================================================
// mux_pipe_stage : N-way registered select mux with valid/ready handshake,
//                  out-of-range flag/count; optional MUX_PIPE_STAGE_SKID_EN skid.
// Revision: 1.0
// ============================================================================
module mux_pipe_stage #(
  parameter int WIDTH = 32,
  parameter int N     = 5,
  parameter int SEL_W = 3,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   in_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err,
  output logic [CNT_W-1:0]   err_cnt
);

  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_err;
  logic             w_acc;
  logic             w_xfer;

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  // Out-of-range selects fall through every lane compare and leave zero.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (in_sel == SEL_W'(i)) begin
        w_sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_sel_err = (32'(in_sel) >= N);
  assign w_acc     = in_valid && in_ready;
  assign w_xfer    = r_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_acc && w_sel_err && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef MUX_PIPE_STAGE_SKID_EN
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_err;

  // Ready depends only on skid occupancy, never on out_ready.
  assign in_ready = !rst && !r_skid_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_err        <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_err   <= 1'b0;
    end else if (w_xfer || !r_valid) begin
      if (r_skid_valid) begin
        r_valid      <= 1'b1;
        r_data       <= r_skid_data;
        r_err        <= r_skid_err;
        r_skid_valid <= 1'b0;
      end else if (w_acc) begin
        r_valid <= 1'b1;
        r_data  <= w_sel_data;
        r_err   <= w_sel_err;
      end else begin
        r_valid <= 1'b0;
      end
    end else if (w_acc) begin
      // Main is stalled: park the new entry without touching main.
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_sel_data;
      r_skid_err   <= w_sel_err;
    end
  end
`else
  assign in_ready = !rst && (!r_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_data  <= w_sel_data;
      r_err   <= w_sel_err;
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end
`endif

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_err   = r_err;
  assign err_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mux_pipe_stage.sv
`default_nettype none
// ============================================================================
// tb_mux_pipe_stage : randomized self-checking bench with a queue-based model.
// Revision: 1.0
// ============================================================================
module tb_mux_pipe_stage;
  localparam int W  = 32;
  localparam int N  = 5;
  localparam int SW = 3;
  localparam int CW = 8;
`ifdef MUX_PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           out_ready;
  logic [N*W-1:0] in_data;
  logic [SW-1:0]  in_sel;
  wire            in_ready, out_valid, out_err;
  wire  [W-1:0]   out_data;
  wire  [CW-1:0]  err_cnt;
  wire            in_ready2, out_valid2, out_err2;
  wire  [W-1:0]   out_data2;
  wire  [1:0]     err_cnt2;

  always #5 clk = ~clk;

  mux_pipe_stage #(.WIDTH(W), .N(N), .SEL_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .err_cnt(err_cnt)
  );

  // Narrow counter instance for saturation.
  mux_pipe_stage #(.WIDTH(W), .N(N), .SEL_W(SW), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_err(out_err2),
    .err_cnt(err_cnt2)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         e;
  } ent_t;

  ent_t q[$];
  int   m_cnt  = 0;
  int   m_cnt2 = 0;
  bit   m_zero = 1'b1;
  int   checks = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [SW-1:0] s,
                      input bit ordy, input bit rnd);
    bit   exp_rdy, acc, xfer;
    ent_t e;
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_sel    = s;
    out_ready = ordy;
    for (int i = 0; i < N; i++)
      in_data[i*W +: W] = rnd ? W'($urandom) : (32'h1000_0000 + 32'(i));
    #1;
    if (r)         exp_rdy = 1'b0;
    else if (SKID) exp_rdy = (q.size() < 2);
    else           exp_rdy = (q.size() == 0) || ordy;
    check_eq("in_ready", in_ready, exp_rdy);
    check_eq("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      check_eq("out_data", out_data, q[0].d);
      check_eq("out_err", out_err, q[0].e);
    end else if (m_zero) begin
      check_eq("out_data_rst", out_data, 0);
      check_eq("out_err_rst", out_err, 0);
    end
    check_eq("err_cnt", err_cnt, m_cnt);
    check_eq("err_cnt_w2", err_cnt2, m_cnt2);
    if (r) begin
      q.delete();
      m_cnt  = 0;
      m_cnt2 = 0;
      m_zero = 1'b1;
    end else begin
      xfer = (q.size() > 0) && ordy;
      acc  = v && exp_rdy;
      if (xfer) void'(q.pop_front());
      if (acc) begin
        e.e = (int'(s) >= N);
        e.d = e.e ? '0 : in_data[int'(s)*W +: W];
        q.push_back(e);
        m_zero = 1'b0;
        if (e.e) begin
          if (m_cnt < (1 << CW) - 1) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_sel = '0; in_data = '0;
    @(posedge clk);
    // Reset held with in_valid high.
    repeat (3) step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
    // Back-to-back lane selects with simultaneous transfer and accept.
    for (int i = 0; i < N; i++) step(1'b0, 1'b1, SW'(i), 1'b1, 1'b0);
    // Out-of-range selects, five of them to saturate the narrow counter.
    for (int i = 5; i < 8; i++) step(1'b0, 1'b1, SW'(i), 1'b1, 1'b0);
    step(1'b0, 1'b1, 3'd7, 1'b1, 1'b0);
    step(1'b0, 1'b1, 3'd5, 1'b1, 1'b0);
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    // Backpressure, then drain.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, SW'(i), 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
    // Reset mid-stall, then idle to show stale entries never reappear.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, SW'(i + 1), 1'b0, 1'b1);
    step(1'b1, 1'b1, 3'd2, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
           SW'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
